operand_issue_stage: RTL and testbench

//  ID->EX issue stage downstream of the register file. Takes decoded fields and raw
//  RS/RT read data, applies EX/MEM forwarding, detects load-use hazards, and holds the
//  ID/EX pipeline register with stall, bubble and flush control.
//  The register file writes on negedge, so the WB->ID path needs no bypass here.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/operand_fwd_mux.sv | 37 +++
 rtl/operand_issue_stage.sv | 140 ++++++++++++++
 tb/tb_operand_issue_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the ID/EX issue path: widths, register zero, forwarding
// select encoding and control-bundle field offsets.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_sel_t;

    // Field layout of the opaque control bundle; EX decodes it, this stage only carries it.
    localparam int CTRL_ALU_OP_LSB     = 0;
    localparam int CTRL_ALU_OP_W       = 4;
    localparam int CTRL_ALU_SRC_BIT    = 4;
    localparam int CTRL_MEM_READ_BIT   = 5;
    localparam int CTRL_MEM_WRITE_BIT  = 6;
    localparam int CTRL_REG_WRITE_BIT  = 7;
    localparam int CTRL_MEM_TO_REG_BIT = 8;
    localparam int CTRL_BRANCH_BIT     = 9;
    localparam int CTRL_JUMP_BIT       = 10;
    localparam int CTRL_WB_SEL_BIT     = 11;

    // x0 beats everything; a load in EX has no result yet, so it never wins.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] addr,
        input logic       ex_regwrite,
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic       mem_regwrite,
        input logic [4:0] mem_rd
    );
        fwd_sel_t sel;
        if (addr == REG_ZERO) begin
            sel = FWD_ZERO;
        end else if (ex_regwrite && !ex_memread && (ex_rd == addr)) begin
            sel = FWD_EX;
        end else if (mem_regwrite && (mem_rd == addr)) begin
            sel = FWD_MEM;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding: picks zero, EX result, MEM result or register-file data.
module operand_fwd_mux #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [4:0]      addr,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_regwrite,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] operand
);
    import riscv_pkg::*;

    fwd_sel_t sel_s;

    // Source selection
    always_comb begin
        sel_s = fwd_select(addr, ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_rd);
    end

    // 4:1 operand mux
    always_comb begin
        operand = {XLEN{1'b0}};
        case (sel_s)
            FWD_ZERO: operand = {XLEN{1'b0}};
            FWD_EX:   operand = ex_result;
            FWD_MEM:  operand = mem_result;
            FWD_RF:   operand = rf_data;
            default:  operand = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/operand_issue_stage.sv
// ID->EX issue stage: operand forwarding, load-use stall and the ID/EX register.
// Optional load-use stall counter enabled by defining STALL_CNT_EN.
module operand_issue_stage #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int CTRL_W = riscv_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              id_valid_i,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              use_rs1_i,
    input  logic              use_rs2_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [XLEN-1:0]   rs_data_i,
    input  logic [XLEN-1:0]   rt_data_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [4:0]        ex_rd_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic              mem_regwrite_i,
    input  logic [4:0]        mem_rd_i,
    input  logic [XLEN-1:0]   mem_result_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [4:0]        ex_rd_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    import riscv_pkg::*;

    logic              rs1_hit_s;
    logic              rs2_hit_s;
    logic              stall_s;
    logic [XLEN-1:0]   rs1_fwd_s;
    logic [XLEN-1:0]   rs2_fwd_s;
    logic              valid_r;
    logic [XLEN-1:0]   rs1_data_r;
    logic [XLEN-1:0]   rs2_data_r;
    logic [XLEN-1:0]   imm_r;
    logic [4:0]        rd_r;
    logic [CTRL_W-1:0] ctrl_r;

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .addr         (rs1_addr_i),
        .ex_regwrite  (ex_regwrite_i),
        .ex_memread   (ex_memread_i),
        .ex_rd        (ex_rd_i),
        .ex_result    (ex_result_i),
        .mem_regwrite (mem_regwrite_i),
        .mem_rd       (mem_rd_i),
        .mem_result   (mem_result_i),
        .rf_data      (rs_data_i),
        .operand      (rs1_fwd_s)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .addr         (rs2_addr_i),
        .ex_regwrite  (ex_regwrite_i),
        .ex_memread   (ex_memread_i),
        .ex_rd        (ex_rd_i),
        .ex_result    (ex_result_i),
        .mem_regwrite (mem_regwrite_i),
        .mem_rd       (mem_rd_i),
        .mem_result   (mem_result_i),
        .rf_data      (rt_data_i),
        .operand      (rs2_fwd_s)
    );

    // Load-use hazard detection; a flushed instruction must never stall
    always_comb begin
        rs1_hit_s = use_rs1_i && (rs1_addr_i == ex_rd_i);
        rs2_hit_s = use_rs2_i && (rs2_addr_i == ex_rd_i);
        if (!reset_n) begin
            stall_s = 1'b0;
        end else if (id_valid_i && ex_memread_i && (ex_rd_i != REG_ZERO) && !flush_i) begin
            stall_s = rs1_hit_s || rs2_hit_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign stall_o = stall_s;

    // ID/EX pipeline register: flush and stall both insert a bubble, data fields hold
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            valid_r    <= 1'b0;
            rs1_data_r <= {XLEN{1'b0}};
            rs2_data_r <= {XLEN{1'b0}};
            imm_r      <= {XLEN{1'b0}};
            rd_r       <= 5'd0;
            ctrl_r     <= {CTRL_W{1'b0}};
        end else if (flush_i || stall_s) begin
            valid_r    <= 1'b0;
            ctrl_r     <= {CTRL_W{1'b0}};
        end else begin
            valid_r    <= id_valid_i;
            rs1_data_r <= rs1_fwd_s;
            rs2_data_r <= rs2_fwd_s;
            imm_r      <= imm_i;
            rd_r       <= rd_addr_i;
            ctrl_r     <= id_valid_i ? ctrl_i : {CTRL_W{1'b0}};
        end
    end

    assign ex_valid_o    = valid_r;
    assign ex_rs1_data_o = rs1_data_r;
    assign ex_rs2_data_o = rs2_data_r;
    assign ex_imm_o      = imm_r;
    assign ex_rd_o       = rd_r;
    assign ex_ctrl_o     = ctrl_r;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Load-use stall cycle counter, wraps naturally
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`else
    assign stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_operand_issue_stage.sv
// Self-checking bench for operand_issue_stage: vector table with a one-deep
// scoreboard for the registered ID/EX outputs, plus a reset-mid-stall sequence.
module tb_operand_issue_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 32;
    localparam int NVEC   = 13;

    logic              clk_i = 1'b0;
    logic              reset_n;
    logic              id_valid_i;
    logic [4:0]        rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic              use_rs1_i, use_rs2_i;
    logic [XLEN-1:0]   imm_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [XLEN-1:0]   rs_data_i, rt_data_i;
    logic              ex_regwrite_i, ex_memread_i;
    logic [4:0]        ex_rd_i;
    logic [XLEN-1:0]   ex_result_i;
    logic              mem_regwrite_i;
    logic [4:0]        mem_rd_i;
    logic [XLEN-1:0]   mem_result_i;
    logic              flush_i;
    logic              stall_o;
    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]        ex_rd_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    operand_issue_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .reset_n        (reset_n),
        .id_valid_i     (id_valid_i),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rd_addr_i      (rd_addr_i),
        .use_rs1_i      (use_rs1_i),
        .use_rs2_i      (use_rs2_i),
        .imm_i          (imm_i),
        .ctrl_i         (ctrl_i),
        .rs_data_i      (rs_data_i),
        .rt_data_i      (rt_data_i),
        .ex_regwrite_i  (ex_regwrite_i),
        .ex_memread_i   (ex_memread_i),
        .ex_rd_i        (ex_rd_i),
        .ex_result_i    (ex_result_i),
        .mem_regwrite_i (mem_regwrite_i),
        .mem_rd_i       (mem_rd_i),
        .mem_result_i   (mem_result_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .ex_valid_o     (ex_valid_o),
        .ex_rs1_data_o  (ex_rs1_data_o),
        .ex_rs2_data_o  (ex_rs2_data_o),
        .ex_imm_o       (ex_imm_o),
        .ex_rd_o        (ex_rd_o),
        .ex_ctrl_o      (ex_ctrl_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        id_valid;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2;
        logic [31:0] imm;
        logic [11:0] ctrl;
        logic [31:0] rsd, rtd;
        logic        exrw, exmr;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        memrw;
        logic [4:0]  memrd;
        logic [31:0] memres;
        logic        flush;
        logic        exp_stall;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_rs1, exp_rs2;
        logic [11:0] exp_ctrl;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        chk_data;
        logic [31:0] rs1, rs2, imm;
        logic [4:0]  rd;
        logic [11:0] ctrl;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   stall_events = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid_i     = v.id_valid;
        rs1_addr_i     = v.rs1;
        rs2_addr_i     = v.rs2;
        rd_addr_i      = v.rd;
        use_rs1_i      = v.use1;
        use_rs2_i      = v.use2;
        imm_i          = v.imm;
        ctrl_i         = v.ctrl;
        rs_data_i      = v.rsd;
        rt_data_i      = v.rtd;
        ex_regwrite_i  = v.exrw;
        ex_memread_i   = v.exmr;
        ex_rd_i        = v.exrd;
        ex_result_i    = v.exres;
        mem_regwrite_i = v.memrw;
        mem_rd_i       = v.memrd;
        mem_result_i   = v.memres;
        flush_i        = v.flush;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, {31'd0, ex_valid_o}, 32'd0);
        check({tag, "_rs1"}, ex_rs1_data_o, 32'd0);
        check({tag, "_rs2"}, ex_rs2_data_o, 32'd0);
        check({tag, "_imm"}, ex_imm_o, 32'd0);
        check({tag, "_rd"}, {27'd0, ex_rd_o}, 32'd0);
        check({tag, "_ctrl"}, {20'd0, ex_ctrl_o}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    endtask

    initial begin
        exp_t e;
        vec_t v;
        // Fields: id_valid rs1 rs2 rd use1 use2 imm ctrl rsd rtd | exrw exmr exrd exres |
        //         memrw memrd memres | flush | exp_stall exp_valid chk_data exp_rs1 exp_rs2 exp_ctrl
        // EX forward to rs1; rs2=x0 reads zero even though RF data is nonzero
        vecs[0]  = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'h10, 12'h0A1, 32'h0, 32'h99,
                     1'b1, 1'b0, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h1234, 32'h0, 12'h0A1};
        // Load-use on rs2: one bubble
        vecs[1]  = '{1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b1, 32'h4, 12'h155, 32'h11, 32'h22,
                     1'b1, 1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 12'h000};
        // Reissue: load result now in MEM
        vecs[2]  = '{1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b1, 32'h4, 12'h155, 32'h11, 32'h22,
                     1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h11, 32'hCAFE, 12'h155};
        // EX beats MEM for the same register
        vecs[3]  = '{1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 32'h8, 12'h00F, 32'h33, 32'h44,
                     1'b1, 1'b0, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'hA, 32'hA, 12'h00F};
        // x0 never forwarded even when EX writes x0; rs2 from MEM
        vecs[4]  = '{1'b1, 5'd0, 5'd2, 5'd1, 1'b1, 1'b1, 32'hFFFF_FFFC, 12'h3FF, 32'h55, 32'h66,
                     1'b1, 1'b0, 5'd0, 32'hFF, 1'b1, 5'd2, 32'h77, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h0, 32'h77, 12'h3FF};
        // Load in EX matches rs1 but rs1 unused: no stall, no EX forward, RF data
        vecs[5]  = '{1'b1, 5'd9, 5'd0, 5'd12, 1'b0, 1'b0, 32'h0, 12'h800, 32'h900, 32'h0,
                     1'b1, 1'b1, 5'd9, 32'hBAD, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h900, 32'h0, 12'h800};
        // Flush with hazard present: flush wins, no stall
        vecs[6]  = '{1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'h4, 12'h155, 32'h11, 32'h0,
                     1'b1, 1'b1, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h000};
        // Invalid ID: data still loaded, ctrl zeroed
        vecs[7]  = '{1'b0, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 32'h20, 12'hFFF, 32'h444, 32'h0,
                     1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b0, 1'b1, 32'h444, 32'h0, 12'h000};
        // Back-to-back loads: x11 load depends on x10 load
        vecs[8]  = '{1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 32'h0, 12'h101, 32'h0, 32'h0,
                     1'b1, 1'b1, 5'd10, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 12'h000};
        vecs[9]  = '{1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 32'h0, 12'h101, 32'h0, 32'h0,
                     1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h1010, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h1010, 32'h0, 12'h101};
        vecs[10] = '{1'b1, 5'd0, 5'd11, 5'd13, 1'b0, 1'b1, 32'h0, 12'h0C0, 32'h0, 32'h0,
                     1'b1, 1'b1, 5'd11, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 12'h000};
        vecs[11] = '{1'b1, 5'd0, 5'd11, 5'd13, 1'b0, 1'b1, 32'h0, 12'h0C0, 32'h0, 32'h0,
                     1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h1111, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h0, 32'h1111, 12'h0C0};
        // Load to x0 in EX never causes a hazard
        vecs[12] = '{1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 32'h1, 12'h001, 32'h0, 32'h0,
                     1'b1, 1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 12'h001};

        v = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 12'h0, 32'h0, 32'h0,
              1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0};
        drive(v);
        reset_n = 1'b0;
        #12;
        check_outputs_zero("por");
        check("por_cnt", stall_cnt_o, 32'd0);
        @(negedge clk_i);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
            if (vecs[i].exp_stall) stall_events++;
            e.valid    = vecs[i].exp_valid;
            e.chk_data = vecs[i].chk_data;
            e.rs1      = vecs[i].exp_rs1;
            e.rs2      = vecs[i].exp_rs2;
            e.imm      = vecs[i].imm;
            e.rd       = vecs[i].rd;
            e.ctrl     = vecs[i].exp_ctrl;
            sb_q.push_back(e);
            @(posedge clk_i);
            #1;
            if (sb_q.size() == 0) begin
                check($sformatf("v%0d_sb_empty", i), 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d_valid", i), {31'd0, ex_valid_o}, {31'd0, e.valid});
                check($sformatf("v%0d_ctrl", i), {20'd0, ex_ctrl_o}, {20'd0, e.ctrl});
                if (e.chk_data) begin
                    check($sformatf("v%0d_rs1", i), ex_rs1_data_o, e.rs1);
                    check($sformatf("v%0d_rs2", i), ex_rs2_data_o, e.rs2);
                    check($sformatf("v%0d_imm", i), ex_imm_o, e.imm);
                    check($sformatf("v%0d_rd", i), {27'd0, ex_rd_o}, {27'd0, e.rd});
                end
            end
        end

`ifdef STALL_CNT_EN
        check("stall_cnt", stall_cnt_o, stall_events);
`else
        check("stall_cnt", stall_cnt_o, 32'd0);
`endif

        // Reset mid-stall: last vector left ex_valid_o=1; present a hazard, then reset
        @(negedge clk_i);
        drive(vecs[1]);
        #1;
        check("pre_rst_stall", {31'd0, stall_o}, 32'd1);
        check("pre_rst_valid", {31'd0, ex_valid_o}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("rst");
        check("rst_cnt", stall_cnt_o, 32'd0);
        @(negedge clk_i);
        reset_n = 1'b1;
        #1;
        check("post_rst_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i);
        #1;
        check("post_rst_bubble", {31'd0, ex_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
